// File: rtl/split_pkg.sv
// Shared types and defaults for the packet split buffer.
// Destination decode maps the packet's select bit onto an output port.
package split_pkg;

   localparam int unsigned WIDTH_DEFAULT    = 32;
   localparam int unsigned DEST_BIT_DEFAULT = WIDTH_DEFAULT - 1;

   typedef logic [WIDTH_DEFAULT-1:0] pkt_t;

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty come from the count, not pointer compare.
// Storage is not reset, so stale entries are only ever exposed through valid-qualified outputs.
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_q];

   // A full FIFO refuses pushes even when a pop happens in the same cycle.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/packet_split_buffer.sv
// Buffers the merged packet stream and steers each head packet, in order, to port 0 or 1.
// Keeps wrapping per-port delivered-packet counters for debug.
module packet_split_buffer
   import split_pkg::*;
#(
   parameter int unsigned WIDTH    = WIDTH_DEFAULT,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned DEST_BIT = WIDTH - 1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     out0_valid,
   input  logic                     out0_ready,
   output logic [WIDTH-1:0]         out0_data,
   output logic                     out1_valid,
   input  logic                     out1_ready,
   output logic [WIDTH-1:0]         out1_data,
   output logic [CNT_W-1:0]         cnt0,
   output logic [CNT_W-1:0]         cnt1,
   output logic [$clog2(DEPTH):0]   occupancy
);

   logic [WIDTH-1:0] head;
   logic             full, empty;
   logic             pop0, pop1;
   port_e            sel;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (in_valid),
      .pop_i   (pop0 || pop1),
      .wdata_i (in_data),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (occupancy)
   );

   assign in_ready = !full;

   // Only the selected port's ready can pop; the other is ignored (head-of-line blocking).
   assign sel        = port_e'(head[DEST_BIT]);
   assign out0_valid = !empty && (sel == PORT0);
   assign out1_valid = !empty && (sel == PORT1);
   assign out0_data  = head;
   assign out1_data  = head;
   assign pop0       = out0_valid && out0_ready;
   assign pop1       = out1_valid && out1_ready;

   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (pop0) cnt0_d = cnt0_q + CNT_W'(1);
      if (pop1) cnt1_d = cnt1_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;

endmodule
